// File: rtl/m_store_buf_pkg.sv
// =============================================================================
// Module      : m_store_buf_pkg
// Description : Shared load/store type codes, byte-enable constants and
//               write-buffer state encoding for the M-stage store path.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

package m_store_buf_pkg;

    // Memory access type codes shared with the M-stage load extender
    localparam logic [3:0] lb_c  = 4'd1;
    localparam logic [3:0] lbu_c = 4'd2;
    localparam logic [3:0] lh_c  = 4'd3;
    localparam logic [3:0] lhu_c = 4'd4;
    localparam logic [3:0] lw_c  = 4'd5;
    localparam logic [3:0] sb_c  = 4'd6;
    localparam logic [3:0] sh_c  = 4'd7;
    localparam logic [3:0] sw_c  = 4'd8;

    localparam logic [3:0] BE_WORD    = 4'b1111;
    localparam logic [3:0] BE_HALF_LO = 4'b0011;
    localparam logic [3:0] BE_HALF_HI = 4'b1100;
    localparam logic [3:0] BE_BYTE0   = 4'b0001;

    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } buf_state_t;

    function automatic logic is_store(input logic [3:0] code);
        return (code == sw_c) || (code == sh_c) || (code == sb_c);
    endfunction

endpackage

`default_nettype wire

// File: rtl/m_store_align.sv
// =============================================================================
// Module      : m_store_align
// Description : Combinational store aligner: byte enables, lane-replicated
//               data and misalignment flag (flag active only when
//               ALIGN_CHECK_EN is defined).
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module m_store_align
    import m_store_buf_pkg::*;
(
    input  logic [3:0]  st_c,
    input  logic [1:0]  a,
    input  logic [31:0] st_data,
    output logic [3:0]  be,
    output logic [31:0] data,
    output logic        misaligned
);

    always_comb begin
        be         = 4'b0000;
        data       = st_data;
        misaligned = 1'b0;
        case (st_c)
            sw_c: be = BE_WORD;
            sh_c: begin
                be   = a[1] ? BE_HALF_HI : BE_HALF_LO;
                data = {2{st_data[15:0]}};
            end
            sb_c: begin
                be   = BE_BYTE0 << a;
                data = {4{st_data[7:0]}};
            end
            default: ;
        endcase
`ifdef ALIGN_CHECK_EN
        misaligned = ((st_c == sh_c) && a[0]) ||
                     ((st_c == sw_c) && (a != 2'b00));
`else
        misaligned = 1'b0;
`endif
    end

endmodule

`default_nettype wire

// File: rtl/m_store_buf.sv
// =============================================================================
// Module      : m_store_buf
// Description : Single-entry store write buffer with req/ack memory handshake.
//               Optional misaligned-store trap enabled by ALIGN_CHECK_EN.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module m_store_buf
    import m_store_buf_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              st_valid,
    input  logic [3:0]        st_c,
    input  logic [ADDR_W-1:0] st_addr,
    input  logic [31:0]       st_data,
    output logic              st_stall,
    output logic              busy,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_be,
    input  logic              mem_ack,
    output logic              st_exc
);

    buf_state_t        r_state;
    buf_state_t        w_state_nxt;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [3:0]        r_be;

    logic              w_store;
    logic              w_full;
    logic              w_drain;
    logic              w_accept;
    logic [3:0]        w_be;
    logic [31:0]       w_data;
    logic              w_misaligned;

    m_store_align u_align (
        .st_c       (st_c),
        .a          (st_addr[1:0]),
        .st_data    (st_data),
        .be         (w_be),
        .data       (w_data),
        .misaligned (w_misaligned)
    );

    assign w_store  = st_valid && is_store(st_c);
    assign w_full   = (r_state == FULL);
    assign w_drain  = w_full && mem_ack;
    assign st_exc   = w_store && w_misaligned;
    assign w_accept = w_store && (!w_full || w_drain) && !st_exc;

    assign st_stall  = w_store && w_full && !mem_ack && !st_exc;
    assign busy      = w_full;
    assign mem_req   = w_full;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign mem_be    = r_be;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= EMPTY;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            EMPTY:   if (w_accept) w_state_nxt = FULL;
            FULL:    if (w_drain && !w_accept) w_state_nxt = EMPTY;
            default: w_state_nxt = EMPTY;
        endcase
    end

    // Payload only moves on accept, so it is frozen while waiting for ack
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr  <= '0;
            r_wdata <= '0;
            r_be    <= '0;
        end else if (w_accept) begin
            r_addr  <= {st_addr[ADDR_W-1:2], 2'b00};
            r_wdata <= w_data;
            r_be    <= w_be;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_m_store_buf.sv
// =============================================================================
// Module      : tb_m_store_buf
// Description : Directed self-checking bench for m_store_buf (ALIGN_CHECK_EN
//               selects the misaligned-store expectations).
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module tb_m_store_buf;
    import m_store_buf_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        st_valid;
    logic [3:0]  st_c;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic        st_stall;
    logic        busy;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic        st_exc;

    int n_vec;
    int n_err;

    m_store_buf #(.ADDR_W(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .st_valid  (st_valid),
        .st_c      (st_c),
        .st_addr   (st_addr),
        .st_data   (st_data),
        .st_stall  (st_stall),
        .busy      (busy),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_be    (mem_be),
        .mem_ack   (mem_ack),
        .st_exc    (st_exc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one edge, then sit 1 ns after it for driving/sampling
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] c, input logic [31:0] ad,
                         input logic [31:0] d, input logic ack);
        st_valid = v;
        st_c     = c;
        st_addr  = ad;
        st_data  = d;
        mem_ack  = ack;
        #1;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;

        // Reset with random inputs
        rst_n = 1'b0;
        drive(1'b1, sw_c, $urandom, $urandom, 1'b1);
        step();
        drive($urandom_range(0, 1), 4'($urandom), $urandom, $urandom, $urandom_range(0, 1));
        step();
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_mem_be", 32'(mem_be), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        drive(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
        rst_n = 1'b1;
        step();
        step();
        chk("post_rst_req", 32'(mem_req), 32'd0);

        // sb 0xA5 to 0x1003
        drive(1'b1, sb_c, 32'h1003, 32'h000000A5, 1'b0);
        chk("sb_stall", 32'(st_stall), 32'd0);
        step();
        drive(1'b0, 4'd0, 32'd0, 32'd0, 1'b1);
        chk("sb_req", 32'(mem_req), 32'd1);
        chk("sb_addr", mem_addr, 32'h1000);
        chk("sb_be", 32'(mem_be), 32'b1000);
        chk("sb_wdata", mem_wdata, 32'hA5A5A5A5);
        chk("sb_busy", 32'(busy), 32'd1);
        step();
        drive(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
        chk("sb_busy_drop", 32'(busy), 32'd0);
        chk("sb_req_drop", 32'(mem_req), 32'd0);

        // Back-to-back sh then sw, ack every cycle
        drive(1'b1, sh_c, 32'h2002, 32'h1234BEEF, 1'b0);
        chk("sh_stall", 32'(st_stall), 32'd0);
        step();
        drive(1'b1, sw_c, 32'h3000, 32'hDEADBEEF, 1'b1);
        chk("sh_be", 32'(mem_be), 32'b1100);
        chk("sh_wdata", mem_wdata, 32'hBEEFBEEF);
        chk("sh_addr", mem_addr, 32'h2000);
        chk("b2b_stall", 32'(st_stall), 32'd0);
        step();
        drive(1'b0, 4'd0, 32'd0, 32'd0, 1'b1);
        chk("sw_req", 32'(mem_req), 32'd1);
        chk("sw_be", 32'(mem_be), 32'b1111);
        chk("sw_wdata", mem_wdata, 32'hDEADBEEF);
        chk("sw_addr", mem_addr, 32'h3000);
        step();
        drive(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
        chk("b2b_req_drop", 32'(mem_req), 32'd0);

        // Stall: sw to 0x40 held 3 cycles without ack, sb waiting behind it
        drive(1'b1, sw_c, 32'h40, 32'h11223344, 1'b0);
        step();
        drive(1'b1, sb_c, 32'h45, 32'h00000077, 1'b0);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("stall_%0d", i), 32'(st_stall), 32'd1);
            chk($sformatf("hold_addr_%0d", i), mem_addr, 32'h40);
            chk($sformatf("hold_be_%0d", i), 32'(mem_be), 32'b1111);
            chk($sformatf("hold_wdata_%0d", i), mem_wdata, 32'h11223344);
            step();
        end
        drive(1'b1, sb_c, 32'h45, 32'h00000077, 1'b1);
        chk("ack_cycle_stall", 32'(st_stall), 32'd0);
        chk("ack_cycle_addr", mem_addr, 32'h40);
        step();
        drive(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
        chk("second_req", 32'(mem_req), 32'd1);
        chk("second_addr", mem_addr, 32'h44);
        chk("second_be", 32'(mem_be), 32'b0010);
        chk("second_wdata", mem_wdata, 32'h77777777);

        // Non-store code while full: no stall, no reload
        drive(1'b1, lw_c, 32'h900, 32'hCAFEF00D, 1'b1);
        chk("nonstore_stall_full", 32'(st_stall), 32'd0);
        step();
        drive(1'b1, lw_c, 32'h900, 32'hCAFEF00D, 1'b0);
        chk("nonstore_req", 32'(mem_req), 32'd0);
        chk("nonstore_stall", 32'(st_stall), 32'd0);
        step();
        chk("nonstore_idle", 32'(mem_req), 32'd0);

        // Misaligned sw to 0x41
        drive(1'b1, sw_c, 32'h41, 32'h55667788, 1'b0);
`ifdef ALIGN_CHECK_EN
        chk("mis_exc", 32'(st_exc), 32'd1);
        chk("mis_stall", 32'(st_stall), 32'd0);
        step();
        drive(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
        chk("mis_req", 32'(mem_req), 32'd0);
`else
        chk("mis_exc", 32'(st_exc), 32'd0);
        step();
        drive(1'b0, 4'd0, 32'd0, 32'd0, 1'b1);
        chk("mis_req", 32'(mem_req), 32'd1);
        chk("mis_addr", mem_addr, 32'h40);
        chk("mis_be", 32'(mem_be), 32'b1111);
        step();
        drive(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
        chk("mis_drain", 32'(mem_req), 32'd0);
`endif

        // Async reset while awaiting ack, then stale ack
        drive(1'b1, sw_c, 32'h80, 32'h0BADCAFE, 1'b0);
        step();
        drive(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
        chk("pre_rst_req", 32'(mem_req), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_req", 32'(mem_req), 32'd0);
        chk("async_rst_busy", 32'(busy), 32'd0);
        step();
        rst_n = 1'b1;
        drive(1'b0, 4'd0, 32'd0, 32'd0, 1'b1);
        step();
        chk("stale_ack_req", 32'(mem_req), 32'd0);
        chk("stale_ack_be", 32'(mem_be), 32'd0);
        chk("stale_ack_addr", mem_addr, 32'd0);
        drive(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
        step();
        chk("stale_ack_idle", 32'(busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
